// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the single regfile write port between the ALU writeback stage
// (single-cycle requests, normally highest priority) and the load unit
// (ready/valid returns buffered in a small FIFO). A starvation counter
// blocks the ALU for one cycle once a live buffered load has lost
// arbitration STARVE_LIMIT times in a row. A younger ALU write to the same
// register kills any buffered load to that register.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   alu_valid/alu_ready   ALU write request / accept
//   alu_addr, alu_data    ALU destination and result
//   ld_valid/ld_ready     load return handshake
//   ld_addr, ld_data      load destination and data
//   reg_write, addr_write, data_write   registered regfile write port
//   ld_count              entries currently buffered
//   busy                  buffer non-empty or a write is being presented
module regfile_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_addr,
  input  logic [31:0]            alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_addr,
  input  logic [31:0]            ld_data,
  output logic                   reg_write,
  output logic [4:0]             addr_write,
  output logic [31:0]            data_write,
  output logic [$clog2(DEPTH):0] ld_count,
  output logic                   busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]   STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // Load buffer storage (data side, never reset) and control state
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic             r_live [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_starve;

  // Registered write port
  logic             r_reg_write;
  logic [4:0]       r_addr_write;
  logic [31:0]      r_data_write;

  logic w_not_empty;
  logic w_head_live;
  logic w_alu_acc;
  logic w_alu_wr;
  logic w_ld_grant;
  logic w_pop;
  logic w_ld_acc;
  logic w_push;
  logic w_push_live;

  // Stage 0: arbitration from registered state and this cycle's requests
  assign w_not_empty = (r_count != '0);
  assign w_head_live = w_not_empty && r_live[r_rd_ptr];

  // alu_ready must not depend on alu_valid, only on registered state.
  assign alu_ready  = !((r_starve == STARVE_MAX) && w_head_live);
  assign w_alu_acc  = alu_valid && alu_ready;
  assign w_alu_wr   = w_alu_acc && (alu_addr != 5'd0);
  // An ALU write to x0 is consumed without using the port, so the head may win.
  assign w_ld_grant = !w_alu_wr && w_head_live;
  // A killed head drains silently whenever it reaches the front.
  assign w_pop      = w_not_empty && (w_ld_grant || !r_live[r_rd_ptr]);

  // Full buffer never accepts, even when it pops in the same cycle.
  assign ld_ready    = (r_count < FULL_CNT);
  assign w_ld_acc    = ld_valid && ld_ready;
  assign w_push      = w_ld_acc && (ld_addr != 5'd0);
  // Loads are older than a concurrent ALU write to the same register.
  assign w_push_live = !(w_alu_wr && (ld_addr == alu_addr));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= ld_addr;
      r_data[r_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_starve     <= '0;
      r_reg_write  <= 1'b0;
      r_addr_write <= 5'd0;
      r_data_write <= 32'd0;
      for (int i = 0; i < DEPTH; i++) r_live[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alu_wr && (r_addr[i] == alu_addr)) r_live[i] <= 1'b0;
      end
      // The push slot is always free, so this never collides with a kill.
      if (w_push) begin
        r_live[r_wr_ptr] <= w_push_live;
        r_wr_ptr         <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A killed head neither counts as losing nor resets the count.
      if (!w_not_empty || w_ld_grant) r_starve <= '0;
      else if (w_head_live && (r_starve != STARVE_MAX)) r_starve <= r_starve + 1'b1;

      // Stage 1: winning write presented to the regfile for one cycle
      r_reg_write <= w_alu_wr || w_ld_grant;
      if (w_alu_wr) begin
        r_addr_write <= alu_addr;
        r_data_write <= alu_data;
      end else if (w_ld_grant) begin
        r_addr_write <= r_addr[r_rd_ptr];
        r_data_write <= r_data[r_rd_ptr];
      end
    end
  end

  assign reg_write  = r_reg_write;
  assign addr_write = r_addr_write;
  assign data_write = r_data_write;
  assign ld_count   = r_count;
  assign busy       = w_not_empty || r_reg_write;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        reg_write;
  logic [4:0]  addr_write;
  logic [31:0] data_write;
  logic [1:0]  ld_count;
  logic        busy;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DEPTH(2), .STARVE_LIMIT(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .reg_write(reg_write), .addr_write(addr_write), .data_write(data_write),
    .ld_count(ld_count), .busy(busy)
  );

  // One cycle of stimulus plus the outputs expected during that cycle.
  // sv/sa/sd: a regfile write the bench now expects next in output order.
  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ar;
    logic        lr;
    logic [1:0]  cnt;
    logic        rw;
    logic        sv;
    logic [4:0]  sa;
    logic [31:0] sd;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int rst, input int av, input int aa, input int ad,
                              input int lv, input int la, input int ld,
                              input int ar, input int lr, input int cnt, input int rw,
                              input int sv, input int sa, input int sd);
    vec_t v;
    v.rst = 1'(rst); v.av = 1'(av); v.aa = 5'(aa); v.ad = 32'(ad);
    v.lv = 1'(lv); v.la = 5'(la); v.ld = 32'(ld);
    v.ar = 1'(ar); v.lr = 1'(lr); v.cnt = 2'(cnt); v.rw = 1'(rw);
    v.sv = 1'(sv); v.sa = 5'(sa); v.sd = 32'(sd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 unit after the next one.
  task automatic cyc(input vec_t v, input string tag);
    wr_t e;
    reset     = v.rst;
    alu_valid = v.av;
    alu_addr  = v.aa;
    alu_data  = v.ad;
    ld_valid  = v.lv;
    ld_addr   = v.la;
    ld_data   = v.ld;
    #1;
    check({tag, " alu_ready"}, 32'(alu_ready), 32'(v.ar));
    check({tag, " ld_ready"},  32'(ld_ready),  32'(v.lr));
    check({tag, " ld_count"},  32'(ld_count),  32'(v.cnt));
    check({tag, " reg_write"}, 32'(reg_write), 32'(v.rw));
    check({tag, " busy"},      32'(busy),      32'((v.cnt != 2'd0) || v.rw));
    if (reg_write === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s unexpected_write: got addr %0d data %0d, expected no write",
                 tag, addr_write, data_write);
      end else begin
        e = sb_q.pop_front();
        check({tag, " addr_write"}, 32'(addr_write), 32'(e.a));
        check({tag, " data_write"}, data_write, e.d);
      end
    end
    if (v.sv) begin
      e.a = v.sa;
      e.d = v.sd;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst addr_write", 32'(addr_write), 32'd0);
    check("rst data_write", data_write, 32'd0);

    //          rst av aa  ad   lv la  ld    ar lr cnt rw  sv sa  sd
    // reset state, then ALU x4=45, x5=64 back to back
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 4, 45,  0, 0, 0,    1, 1, 0, 0,  1, 4, 45));
    tbl.push_back(mk(0, 1, 5, 64,  0, 0, 0,    1, 1, 0, 1,  1, 5, 64));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    // load x7=256 with ALU idle
    tbl.push_back(mk(0, 0, 0, 0,   1, 7, 256,  1, 1, 0, 0,  1, 7, 256));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 1, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    // starvation: ALU every cycle, load x9=99 waits 3 losses
    tbl.push_back(mk(0, 1, 1, 11,  1, 9, 99,   1, 1, 0, 0,  1, 1, 11));
    tbl.push_back(mk(0, 1, 2, 12,  0, 0, 0,    1, 1, 1, 1,  1, 2, 12));
    tbl.push_back(mk(0, 1, 3, 13,  0, 0, 0,    1, 1, 1, 1,  1, 3, 13));
    tbl.push_back(mk(0, 1, 10, 14, 0, 0, 0,    1, 1, 1, 1,  1, 10, 14));
    tbl.push_back(mk(0, 1, 11, 15, 0, 0, 0,    0, 1, 1, 1,  1, 9, 99));
    tbl.push_back(mk(0, 1, 11, 15, 0, 0, 0,    1, 1, 0, 1,  1, 11, 15));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    // kill: load x6=10 buffered, then ALU x6=20
    tbl.push_back(mk(0, 0, 0, 0,   1, 6, 10,   1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 6, 20,  0, 0, 0,    1, 1, 1, 0,  1, 6, 20));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 1, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    // full buffer, third load held, pointer wrap
    tbl.push_back(mk(0, 1, 12, 1,  1, 13, 100, 1, 1, 0, 0,  1, 12, 1));
    tbl.push_back(mk(0, 1, 14, 2,  1, 15, 101, 1, 1, 1, 1,  1, 14, 2));
    tbl.push_back(mk(0, 1, 16, 3,  1, 17, 102, 1, 0, 2, 1,  1, 16, 3));
    tbl.push_back(mk(0, 1, 18, 4,  1, 17, 102, 1, 0, 2, 1,  1, 18, 4));
    tbl.push_back(mk(0, 1, 19, 5,  1, 17, 102, 0, 0, 2, 1,  1, 13, 100));
    tbl.push_back(mk(0, 1, 19, 5,  1, 17, 102, 1, 1, 1, 1,  1, 19, 5));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 0, 2, 1,  1, 15, 101));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 1, 1,  1, 17, 102));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    // x0 writes from both sources; ALU x0 lets a live head through
    tbl.push_back(mk(0, 1, 0, 77,  1, 0, 88,   1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   1, 20, 7,   1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 9,   0, 0, 0,    1, 1, 1, 0,  1, 20, 7));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    // reset with two buffered loads
    tbl.push_back(mk(0, 1, 21, 1,  1, 22, 200, 1, 1, 0, 0,  1, 21, 1));
    tbl.push_back(mk(0, 1, 23, 2,  1, 24, 201, 1, 1, 1, 1,  1, 23, 2));
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0,    1, 0, 2, 1,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0,    1, 1, 0, 0,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("v%0d", i));

    check("post-reset addr_write", 32'(addr_write), 32'd0);
    check("post-reset data_write", data_write, 32'd0);

    // Load and ALU to x8 in the same cycle: the load is older and must die.
    cyc(mk(0, 1, 8, 60, 1, 8, 50,  1, 1, 0, 0,  1, 8, 60), "h0");
    cyc(mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 1, 1,  0, 0, 0),  "h1");
    cyc(mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0,  0, 0, 0),  "h2");
    cyc(mk(0, 0, 0, 0,  0, 0, 0,   1, 1, 0, 0,  0, 0, 0),  "h3");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback sources. The ALU/writeback stage issues single-cycle writes. The load unit returns data at arbitrary times through a ready/valid handshake. The block buffers load returns in a small FIFO, normally gives the ALU priority, and prevents load starvation. It drops stale load results when a younger ALU write targets the same register. It sits between the pipeline writeback logic and the regfile write inputs (reg_write, addr_write, data_write).

Parameters:
DEPTH, 2, load buffer entries (power of two, >=2)
STARVE_LIMIT, 3, consecutive cycles a live buffered load may lose arbitration before ALU is blocked
CNT_W, 2, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
alu_valid  input  1  ALU write request this cycle
alu_ready  output  1  ALU request accepted when alu_valid && alu_ready
alu_addr  input  5  ALU destination register
alu_data  input  32  ALU result
ld_valid  input  1  load return valid
ld_ready  output  1  buffer can accept load return
ld_addr  input  5  load destination register
ld_data  input  32  load data
reg_write  output  1  regfile write enable (registered)
addr_write  output  5  regfile write address (registered)
data_write  output  32  regfile write data (registered)
ld_count  output  $clog2(DEPTH)+1  entries currently buffered
busy  output  1  ld_count != 0 or reg_write

Behaviour:
- Reset: reg_write=0, addr_write=0, data_write=0, buffer empty, ld_count=0, starvation counter=0, all live bits cleared. Reset has priority over every event. Buffered loads are discarded on reset.
- Buffer entry holds {addr, data, live}. Load accepted when ld_valid && ld_ready; ld_ready = (ld_count < DEPTH). The entry is written at the end of that cycle with live=1.
- Load with ld_addr=0: handshake completes, nothing enqueued.
- alu_ready = !(starve_cnt == STARVE_LIMIT && head live). Combinational from registered state only, not from alu_valid.
- Grant per cycle:
  - ALU accepted with alu_addr!=0 → ALU owns the port.
  - Else if head is live → load head owns the port and is popped.
  - ALU accepted with alu_addr=0 consumes the request and emits no write, so a live head may take the port in that same cycle.
- Killed (non-live) head: popped in any cycle, without using the port. At most one pop per cycle.
- Output latency: the winning write appears on reg_write/addr_write/data_write for exactly the following cycle. reg_write=0 in cycles with no grant; addr/data hold previous values.
- Kill rule: when ALU is granted with addr A!=0, clear live on every buffered entry with addr A. This includes a load with ld_addr=A accepted in the same cycle. Loads are always older than a concurrent ALU write.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) each cycle the head is live and not granted;
  - clears when the head is granted or the buffer is empty.
- Simultaneous pop and push with a full buffer: ld_ready is still 0 (no bypass of full).
- Pointers wrap modulo DEPTH. ld_count always equals pushes minus pops.
- Load latency from accept to regfile outputs is at least 2 cycles; ALU latency is exactly 1 cycle when ready.

Test Plan:
- Reset then ALU writes 45 to x4, 64 to x5 on consecutive cycles → reg_write high two cycles, addr 4/5, data 45/64, each one cycle after request.
- Load x7=256 with ALU idle → ld_ready=1, reg_write with addr 7, data 256 two cycles after accept; ld_count 1→0.
- ALU valid every cycle, load x9=99 buffered (STARVE_LIMIT=3) → ALU wins 3 cycles, then alu_ready=0 for one cycle, x9=99 written, alu_ready returns to 1.
- Load x6=10 buffered, then ALU writes x6=20 → only x6=20 reaches the regfile; the killed entry pops silently and ld_count returns to 0.
- Two loads accepted while ALU busy (DEPTH=2) → ld_ready=0; third ld_valid held until a pop, then accepted. All three are written in order; no loss after pointer wrap.
- ALU write to x0 and load to x0 → no reg_write pulse for either. Assert reset mid-drain with 2 entries → next cycle ld_count=0, reg_write=0, and no buffered write is emitted afterward.
